// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and build timestamp over Avalon-MM,
// retries on mismatch and publishes sticky pass/fail status.
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1429586131,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned MAX_RETRIES        = 2,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic        pass,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [2:0]  retry_count,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE} state_t;

   state_t      state;
   logic        pending;
   logic [15:0] tmo_cnt;
   logic [1:0]  lat_cnt;
   logic        is_ts;
   logic        go;
   logic        capture_now;

   assign fsm_state = state;

   // Handshake: a read is accepted on a cycle with avm_read=1 and avm_waitrequest=0;
   // address and read stay stable until then. Data is valid READ_LATENCY cycles later.
   always_comb begin
      is_ts       = (state == RD_TS) || (state == WT_TS);
      go          = ((state == IDLE) && (pending || start)) || ((state == DONE) && start);
      capture_now = (((state == RD_ID) || (state == RD_TS)) && !avm_waitrequest && (READ_LATENCY == 0))
                 || (((state == WT_ID) || (state == WT_TS)) && (lat_cnt == 2'(READ_LATENCY)));
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         pending     <= AUTO_START;
         tmo_cnt     <= '0;
         lat_cnt     <= '0;
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_match    <= 1'b0;
         ts_match    <= 1'b0;
         pass        <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
         retry_count <= '0;
      end else if (go) begin
         pending     <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout_err <= 1'b0;
         retry_count <= '0;
         busy        <= 1'b1;
         avm_read    <= 1'b1;
         avm_address <= 1'b0;
         tmo_cnt     <= '0;
         state       <= RD_ID;
      end else if (capture_now) begin
         tmo_cnt <= '0;
         if (is_ts) begin
            ts_value    <= avm_readdata;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            state       <= CHECK;
         end else begin
            id_value    <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            state       <= RD_TS;
         end
      end else begin
         case (state)
            RD_ID, RD_TS: begin
               if (avm_waitrequest) begin
                  // Timeout ends the check outright; it is never retried.
                  if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                     avm_read    <= 1'b0;
                     avm_address <= 1'b0;
                     timeout_err <= 1'b1;
                     pass        <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 16'd1;
                  end
               end else begin
                  tmo_cnt  <= '0;
                  avm_read <= 1'b0;
                  lat_cnt  <= 2'd1;
                  state    <= is_ts ? WT_TS : WT_ID;
               end
            end
            WT_ID, WT_TS: lat_cnt <= lat_cnt + 2'd1;
            CHECK: begin
               id_match <= (id_value == EXPECTED_ID);
               ts_match <= (ts_value == EXPECTED_TIMESTAMP);
               if ((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP)) begin
                  pass  <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (retry_count < 3'(MAX_RETRIES)) begin
                  retry_count <= retry_count + 3'd1;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= RD_ID;
               end else begin
                  pass  <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two instances (READ_LATENCY 0 and 2), a reactive
// slave model, and a completion scoreboard fed by a behavioural run model.
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID   = 32'h0000_0000;
   localparam logic [31:0] EXP_TS   = 32'd1429586131;
   localparam int          MAX_RET  = 2;
   localparam int          TIMEOUT  = 255;

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] idv;
      logic [31:0] tsv;
      logic [7:0]  reads;
      logic [2:0]  retry;
      logic        pass;
      logic        idm;
      logic        tsm;
      logic        tmo;
      logic        inst;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic        clock = 1'b0;
   logic        reset_n [2];
   logic        start [2];
   logic        avm_address [2];
   logic        avm_read [2];
   logic [31:0] avm_readdata [2];
   logic        avm_waitrequest [2];
   logic        busy [2];
   logic        done [2];
   logic        id_match [2];
   logic        ts_match [2];
   logic        pass [2];
   logic        timeout_err [2];
   logic [31:0] id_value [2];
   logic [31:0] ts_value [2];
   logic [2:0]  retry_count [2];
   logic [2:0]  fsm_state [2];
   int          acc_reads [2];

   // Slave behaviour, shared by whichever instance is active.
   logic [31:0] slv_id, slv_ts;
   int          slv_stall;
   bit          slv_hang;

   // Run model state (last captured words and match flags per instance).
   logic [31:0] m_id [2];
   logic [31:0] m_ts [2];
   logic        m_idm [2];
   logic        m_tsm [2];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = g * 2;

      sysid_boot_checker #(
         .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(LAT),
         .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(MAX_RET), .AUTO_START(1'b1)
      ) dut (
         .clock(clock), .reset_n(reset_n[g]), .start(start[g]),
         .avm_address(avm_address[g]), .avm_read(avm_read[g]),
         .avm_readdata(avm_readdata[g]), .avm_waitrequest(avm_waitrequest[g]),
         .busy(busy[g]), .done(done[g]), .id_match(id_match[g]), .ts_match(ts_match[g]),
         .pass(pass[g]), .timeout_err(timeout_err[g]), .id_value(id_value[g]),
         .ts_value(ts_value[g]), .retry_count(retry_count[g]), .fsm_state(fsm_state[g])
      );

      int          stall_cnt;
      int          pend_cnt;
      bit          pend;
      logic [31:0] pend_data;
      logic        prev_stall, prev_addr, prev_done;
      exp_t        e;

      always @(negedge clock) begin
         if (reset_n[g] !== 1'b1) begin
            stall_cnt = 0; pend = 0; prev_stall = 0; prev_done = 0;
            avm_waitrequest[g] = 1'b0;
            avm_readdata[g] = $urandom;
         end else begin
            // A stalled read must hold address and strobe, unless it timed out.
            if (prev_stall) begin
               checks++;
               if (!((avm_read[g] && avm_address[g] == prev_addr) || (!avm_read[g] && timeout_err[g]))) begin
                  errors++;
                  $display("FAIL stall_hold inst%0d actual read=%b addr=%b required read=1 addr=%b", g,
                           avm_read[g], avm_address[g], prev_addr);
               end
            end
            // Monitor: every rising edge of done retires one expected run.
            if (done[g] && !prev_done) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done inst%0d actual=1 required=0 (cycle %0d)", g, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("inst", 32'(g), 32'(e.inst));
                  chk("done_cycle", cyc, e.cyc);
                  chk("busy_at_done", 32'(busy[g]), 32'd0);
                  chk("pass", 32'(pass[g]), 32'(e.pass));
                  chk("id_match", 32'(id_match[g]), 32'(e.idm));
                  chk("ts_match", 32'(ts_match[g]), 32'(e.tsm));
                  chk("timeout_err", 32'(timeout_err[g]), 32'(e.tmo));
                  chk("retry_count", 32'(retry_count[g]), 32'(e.retry));
                  chk("id_value", id_value[g], e.idv);
                  chk("ts_value", ts_value[g], e.tsv);
                  chk("read_count", acc_reads[g], 32'(e.reads));
               end
               acc_reads[g] = 0;
            end
            prev_done = done[g];
            // Slave response for the coming edge; garbage whenever data is not due.
            avm_readdata[g] = $urandom;
            if (pend) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  avm_readdata[g] = pend_data;
                  pend = 0;
               end
            end
            if (avm_read[g]) begin
               if (slv_hang || stall_cnt < slv_stall) begin
                  avm_waitrequest[g] = 1'b1;
                  stall_cnt++;
               end else begin
                  avm_waitrequest[g] = 1'b0;
                  stall_cnt = 0;
                  acc_reads[g]++;
                  if (LAT == 0) avm_readdata[g] = avm_address[g] ? slv_ts : slv_id;
                  else begin
                     pend = 1; pend_cnt = LAT;
                     pend_data = avm_address[g] ? slv_ts : slv_id;
                  end
               end
            end else begin
               avm_waitrequest[g] = 1'b0;
               stall_cnt = 0;
            end
            prev_stall = avm_read[g] && avm_waitrequest[g];
            prev_addr  = avm_address[g];
         end
      end
   end

   // Expected outcome of one check launched in cycle st_cyc.
   task automatic expect_run(input int g, input int st_cyc);
      exp_t e;
      int   passes, per, lat;
      lat = (g == 1) ? 2 : 0;
      e.inst = g[0];
      if (slv_hang) begin
         e.tmo = 1'b1; e.pass = 1'b0; e.retry = 3'd0; e.reads = 8'd0;
         e.idm = m_idm[g]; e.tsm = m_tsm[g]; e.idv = m_id[g]; e.tsv = m_ts[g];
         e.cyc = 32'(st_cyc + TIMEOUT + 1);
      end else begin
         e.idm = (slv_id == EXP_ID);
         e.tsm = (slv_ts == EXP_TS);
         passes = (e.idm && e.tsm) ? 1 : MAX_RET + 1;
         per = 2 * (slv_stall + 1 + lat) + 1;
         e.cyc = 32'(st_cyc + passes * per + 1);
         e.tmo = 1'b0; e.pass = e.idm && e.tsm; e.retry = 3'(passes - 1);
         e.reads = 8'(2 * passes); e.idv = slv_id; e.tsv = slv_ts;
         m_id[g] = slv_id; m_ts[g] = slv_ts; m_idm[g] = e.idm; m_tsm[g] = e.tsm;
      end
      exp_q.push_back(e);
   endtask

   task automatic run_start(input int g);
      @(negedge clock);
      start[g] = 1'b1;
      expect_run(g, cyc);
      @(negedge clock);
      start[g] = 1'b0;
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() > 0; i++) @(negedge clock);
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual pending=%0d required pending=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_zero(input int g);
      chk("rst_read", 32'(avm_read[g]), 32'd0);
      chk("rst_addr", 32'(avm_address[g]), 32'd0);
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_done", 32'(done[g]), 32'd0);
      chk("rst_id_match", 32'(id_match[g]), 32'd0);
      chk("rst_ts_match", 32'(ts_match[g]), 32'd0);
      chk("rst_pass", 32'(pass[g]), 32'd0);
      chk("rst_timeout", 32'(timeout_err[g]), 32'd0);
      chk("rst_id_value", id_value[g], 32'd0);
      chk("rst_ts_value", ts_value[g], 32'd0);
      chk("rst_retry", 32'(retry_count[g]), 32'd0);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 2; i++) begin
         reset_n[i] = 1'b0; start[i] = 1'b0; acc_reads[i] = 0;
         m_id[i] = '0; m_ts[i] = '0; m_idm[i] = 1'b0; m_tsm[i] = 1'b0;
      end
      slv_id = EXP_ID; slv_ts = EXP_TS; slv_stall = 0; slv_hang = 0;
      repeat (3) @(negedge clock);
      check_zero(0);
      check_zero(1);

      // Auto-start after reset with a zero-wait, correct slave.
      reset_n[0] = 1'b1;
      expect_run(0, cyc);
      drain(600);

      // Wrong timestamp: full retry sequence.
      slv_ts = 32'h1234_5678;
      run_start(0);
      drain(600);

      // Five stall cycles on every read.
      slv_ts = EXP_TS; slv_stall = 5;
      run_start(0);
      drain(600);

      // Randomized stalls and data.
      for (int n = 0; n < 6; n++) begin
         slv_stall = $urandom_range(0, 3);
         slv_id = ($urandom_range(0, 2) == 0) ? ($urandom | 32'd1) : EXP_ID;
         slv_ts = ($urandom_range(0, 2) == 0) ? (EXP_TS ^ ($urandom | 32'd1)) : EXP_TS;
         run_start(0);
         drain(600);
      end

      // Permanent stall.
      slv_hang = 1;
      run_start(0);
      drain(600);
      slv_hang = 0;

      // Second instance, READ_LATENCY=2.
      slv_id = EXP_ID; slv_ts = EXP_TS; slv_stall = $urandom_range(0, 2);
      @(negedge clock);
      reset_n[1] = 1'b1;
      expect_run(1, cyc);
      drain(600);

      // Start while busy is ignored; an extra run would show up as an unexpected done.
      run_start(1);
      repeat (3) @(negedge clock);
      start[1] = 1'b1;
      @(negedge clock);
      start[1] = 1'b0;
      drain(600);
      repeat (25) @(negedge clock);

      // Reset during the second pass's timestamp wait.
      slv_stall = 0;
      slv_ts = 32'hdead_beef;
      run_start(1);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         if (retry_count[1] == 3'd1 && avm_address[1] && !avm_read[1] && busy[1]) found = 1;
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL reach_wt_ts actual=0 required=1");
      end
      reset_n[1] = 1'b0;
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      m_id[1] = '0; m_ts[1] = '0; m_idm[1] = 1'b0; m_tsm[1] = 1'b0;
      acc_reads[1] = 0;
      @(negedge clock);
      check_zero(1);
      slv_ts = EXP_TS;
      reset_n[1] = 1'b1;
      expect_run(1, cyc);
      drain(600);
      run_start(1);
      drain(600);
      repeat (5) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its 32-bit readdata.
- After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp) and compares both with expected values.
- It retries on mismatch, then publishes sticky pass/fail status and the captured words to the boot/status logic.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0.
- EXPECTED_TIMESTAMP, 32'd1429586131, expected word at address 1.
- READ_LATENCY, 0, cycles from the accepting cycle to valid readdata; legal range 0..3.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles per read; legal range 1..65535.
- MAX_RETRIES, 2, additional full read passes after a mismatch; legal range 0..7.
- AUTO_START, 1, start one check automatically after reset deasserts.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to run a check; ignored while busy.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave.
- busy  out  1  check in progress.
- done  out  1  check finished; level, held until the next start.
- id_match  out  1  last captured ID equals EXPECTED_ID.
- ts_match  out  1  last captured timestamp equals EXPECTED_TIMESTAMP.
- pass  out  1  id_match & ts_match & ~timeout_err, valid when done=1.
- timeout_err  out  1  a read exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- retry_count  out  3  mismatch retries used in the last check.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clock, reset port is reset_n.
- Reset (reset_n=0 sampled on a clock edge):
  - All outputs are 0: avm_read, avm_address, busy, done, id_match, ts_match, pass, timeout_err, id_value, ts_value, retry_count.
  - State goes to IDLE.
  - If AUTO_START=1, an internal pending flag is set.
  - Reset mid-read drops avm_read at that edge; no partial result survives.
- All outputs are registered.
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE.
- IDLE:
  - Leaves when pending=1 or start=1: clears pending, done, pass, timeout_err and retry_count; sets busy; goes to RD_ID.
- RD_ID:
  - avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - Acceptance is a cycle with avm_read=1 and avm_waitrequest=0.
  - READ_LATENCY=0: id_value captures avm_readdata in the accepting cycle; go to RD_TS.
  - READ_LATENCY>0: avm_read drops on the next edge; go to WT_ID; capture exactly READ_LATENCY cycles after the accepting cycle; then go to RD_TS.
- RD_TS / WT_TS: identical to RD_ID / WT_ID with avm_address=1; capture goes to ts_value; then go to CHECK.
- Timeout:
  - Per-read counter increments each cycle with avm_read=1 and avm_waitrequest=1; it clears on acceptance.
  - When it reaches TIMEOUT_CYCLES: drop avm_read, set timeout_err=1, and go to DONE with pass=0. No retry on timeout.
- CHECK (one cycle):
  - id_match and ts_match are registered from full 32-bit equality.
  - Both match: go to DONE.
  - Any mismatch with retry_count<MAX_RETRIES: retry_count+1, back to RD_ID.
  - Otherwise: go to DONE.
- DONE:
  - busy=0, done=1, pass registered.
  - Holds until start=1, which behaves like the IDLE exit in the same cycle.
- start while busy=1 is ignored and not queued.
- Zero-wait, READ_LATENCY=0, AUTO_START=1 timeline (cycle 0 = first cycle with reset_n=1):
  - cycle 1: RD_ID, busy=1.
  - cycle 2: RD_TS.
  - cycle 3: CHECK.
  - done=1 and pass visible from cycle 4.
- Each retry pass adds 3 cycles with zero waitrequest.
- retry_count saturates at MAX_RETRIES and is never wrapped.

Test Plan:
- Zero-wait slave returning 0 / 1429586131, defaults -> reads at address 0 then 1 in cycles 1 and 2; done=1, pass=1, retry_count=0 at cycle 4.
- Slave returning timestamp 0x12345678 -> three full passes (initial + 2 retries); done=1, id_match=1, ts_match=0, pass=0, retry_count=2, ts_value=0x12345678.
- Stall every read with waitrequest=1 for 5 cycles -> address/read held stable; capture on the accepting cycle; pass=1, done at cycle 14.
- Hold waitrequest=1 permanently, TIMEOUT_CYCLES=255 -> avm_read drops after 255 stall cycles; timeout_err=1, pass=0, done=1.
- READ_LATENCY=2 with data valid only 2 cycles after acceptance -> correct words captured, pass=1; start pulsed while busy has no effect.
- reset_n=0 for one cycle during WT_TS, then a start pulse from DONE -> all outputs 0 after reset; check reruns cleanly with retry_count reset to 0.
